// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and DRAM-side signals around mem_port_arbiter.
// slave = the arbiter itself; master = the caches plus the DRAM controller.
`timescale 1ns/1ps
interface mem_port_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 16,
  parameter int PAGE_W  = 128
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  // Requester side.
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        we;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ*PAGE_W-1:0] wdata;
  logic [NUM_REQ-1:0]        strobe;
  logic [PAGE_W-1:0]         rdata;
  logic                      grant_valid;
  logic [ID_W-1:0]           grant_id;

  // DRAM controller side.
  logic                      mem_req;
  logic                      mem_we;
  logic [ADDR_W-1:0]         mem_addr;
  logic [PAGE_W-1:0]         mem_wdata;
  logic                      mem_ack;
  logic [PAGE_W-1:0]         mem_rdata;
  logic                      timeout_err;

  modport slave (
    input  req, we, addr, wdata, mem_ack, mem_rdata,
    output strobe, rdata, grant_valid, grant_id,
           mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );

  modport master (
    output req, we, addr, wdata, mem_ack, mem_rdata,
    input  strobe, rdata, grant_valid, grant_id,
           mem_req, mem_we, mem_addr, mem_wdata, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one DRAM page port between NUM_REQ caches.
// Optional ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_W         = 16,
  parameter int PAGE_W         = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk_i,
  input  logic                reset_i,
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          state_o
);
  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEM     = 2'd1;
  localparam logic [1:0] S_STROBE  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mem_port_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]         state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    grant_id_q, grant_id_d;
  logic               grant_valid_q, grant_valid_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [PAGE_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [PAGE_W-1:0]  rdata_q, rdata_d;
  logic [NUM_REQ-1:0] strobe_q, strobe_d;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TO_W   = (TO_RAW < 8) ? 8 : ((TO_RAW > 16) ? 16 : TO_RAW);
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               timeout_err_q, timeout_err_d;
`endif

  // Round-robin pick: first requesting index at or after rr_ptr, wrapping.
  logic               pick_found;
  logic [ID_W-1:0]    pick_id;
  logic [ID_W-1:0]    cand;

  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (int'(rr_ptr_q) + k >= NUM_REQ) cand = ID_W'(int'(rr_ptr_q) + k - NUM_REQ);
      else                               cand = ID_W'(int'(rr_ptr_q) + k);
      if (!pick_found && bus.req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    rdata_d       = rdata_q;
    strobe_d      = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_id_d    = pick_id;
          grant_valid_d = 1'b1;
          mem_req_d     = 1'b1;
          mem_we_d      = bus.we[pick_id];
          mem_addr_d    = bus.addr[pick_id*ADDR_W +: ADDR_W];
          mem_wdata_d   = bus.wdata[pick_id*PAGE_W +: PAGE_W];
`ifdef MEM_ARB_TIMEOUT_EN
          to_cnt_d      = '0;
`endif
          state_d       = S_MEM;
        end
      end
      S_MEM: begin
`ifdef MEM_ARB_TIMEOUT_EN
        to_cnt_d = to_cnt_q + 1'b1;
`endif
        if (bus.mem_ack) begin
          mem_req_d            = 1'b0;
          if (!mem_we_q) rdata_d = bus.mem_rdata;
          strobe_d[grant_id_q] = 1'b1;
          state_d              = S_STROBE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Give up on the DRAM but still release the requester; rdata untouched.
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          mem_req_d            = 1'b0;
          timeout_err_d        = 1'b1;
          strobe_d[grant_id_q] = 1'b1;
          state_d              = S_STROBE;
        end
`endif
      end
      S_STROBE: begin
        state_d = S_RELEASE;
      end
      default: begin
        if (!bus.req[grant_id_q]) begin
          grant_valid_d = 1'b0;
          if (int'(grant_id_q) == NUM_REQ - 1) rr_ptr_d = '0;
          else                                 rr_ptr_d = grant_id_q + ID_W'(1);
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      rdata_q       <= '0;
      strobe_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      rdata_q       <= rdata_d;
      strobe_q      <= strobe_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      to_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.strobe      = strobe_q;
  assign bus.rdata       = rdata_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign state_o         = state_q;

  a_strobe_onehot: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(strobe_q));
  a_mem_req_state: assert property (@(posedge clk_i) disable iff (reset_i) mem_req_q |-> state_q == S_MEM);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard of expected completions checked on strobe.
// Define MEM_ARB_TIMEOUT_EN for both bench and RTL to exercise the watchdog.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int NUM_REQ        = 2;
  localparam int ADDR_W         = 16;
  localparam int PAGE_W         = 128;
  localparam int TIMEOUT_CYCLES = 10;
  localparam int ID_W           = 1;
  localparam int E_W            = ID_W + 1 + ADDR_W + 2*PAGE_W;
  localparam logic [PAGE_W-1:0] DEADBEEF = 128'hDEAD0000_11112222_33334444_0000BEEF;
  localparam logic [PAGE_W-1:0] PAT_A5   = {16{8'hA5}};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .PAGE_W(PAGE_W)) bus ();

  mem_port_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus),
    .state_o (state_dbg)
  );

  int tests  = 0;
  int errors = 0;
  logic [E_W-1:0]    exp_q[$];
  logic [PAGE_W-1:0] rdata_model;

  // responder controls
  int                ack_delay   = 0;
  bit                no_ack      = 0;
  bit                stray_req   = 0;
  bit                resp_fixed_en = 0;
  logic [PAGE_W-1:0] resp_fixed  = '0;

  task automatic chk(input string name, input logic [PAGE_W-1:0] act, input logic [PAGE_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [PAGE_W-1:0] page_of(input logic [ADDR_W-1:0] a);
    return {(PAGE_W/ADDR_W){a}} ^ {4{32'h5A5A_0F0F}};
  endfunction

  task automatic push_exp(input int id, input logic we_v, input logic [ADDR_W-1:0] a,
                          input logic [PAGE_W-1:0] wd, input logic [PAGE_W-1:0] rd);
    exp_q.push_back({ID_W'(id), we_v, a, wd, rd});
  endtask

  // ---------------- DRAM responder model ----------------
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (stray_req) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = '1;
        stray_req     = 0;
      end else if (bus.mem_req && !no_ack) begin
        if (wait_cnt >= ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = resp_fixed_en ? resp_fixed : page_of(bus.mem_addr);
          wait_cnt      = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin : monitor
    logic [E_W-1:0]    e;
    logic [ID_W-1:0]   e_id;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [PAGE_W-1:0] e_wd, e_rd;
    forever begin
      @(negedge clk);
      if (!reset && bus.strobe != '0) begin
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL strobe_unexpected: got strobe %b expected none", bus.strobe);
        end else begin
          e = exp_q.pop_front();
          {e_id, e_we, e_addr, e_wd, e_rd} = e;
          chk("strobe_onehot", PAGE_W'(bus.strobe), PAGE_W'(1) << e_id);
          chk("grant_id", PAGE_W'(bus.grant_id), PAGE_W'(e_id));
          chk("grant_valid", PAGE_W'(bus.grant_valid), PAGE_W'(1));
          chk("mem_req_low", PAGE_W'(bus.mem_req), PAGE_W'(0));
          chk("mem_we", PAGE_W'(bus.mem_we), PAGE_W'(e_we));
          chk("mem_addr", PAGE_W'(bus.mem_addr), PAGE_W'(e_addr));
          if (e_we) chk("mem_wdata", bus.mem_wdata, e_wd);
          chk("rdata", bus.rdata, e_rd);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.grant_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("release_grant_valid", PAGE_W'(bus.grant_valid), PAGE_W'(0));
  endtask

  task automatic single_txn(input int id, input logic we_v, input logic [ADDR_W-1:0] a,
                            input logic [PAGE_W-1:0] wd, input logic [PAGE_W-1:0] rd,
                            input int delay, input bit drop_early, input bit mutate);
    int lat;
    bit seen;
    logic [PAGE_W-1:0] exp_rd;
    ack_delay     = delay;
    resp_fixed    = rd;
    resp_fixed_en = 1;
    bus.we[id]    = we_v;
    bus.addr[id*ADDR_W +: ADDR_W]  = a;
    bus.wdata[id*PAGE_W +: PAGE_W] = wd;
    bus.req[id]   = 1'b1;
    exp_rd        = we_v ? rdata_model : rd;
    rdata_model   = exp_rd;
    push_exp(id, we_v, a, wd, exp_rd);
    lat  = 0;
    seen = 0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("grant_id_at_grant", PAGE_W'(bus.grant_id), PAGE_W'(id));
        chk("mem_req_up", PAGE_W'(bus.mem_req), PAGE_W'(1));
        if (drop_early) bus.req[id] = 1'b0;
        if (mutate) begin
          bus.addr[id*ADDR_W +: ADDR_W]  = ~a;
          bus.wdata[id*PAGE_W +: PAGE_W] = ~wd;
        end
      end
      if (mutate && bus.mem_req) begin
        chk("mem_addr_stable", PAGE_W'(bus.mem_addr), PAGE_W'(a));
        chk("mem_wdata_stable", bus.mem_wdata, wd);
      end
      if (bus.strobe[id]) seen = 1;
    end
    chk("strobe_latency", PAGE_W'(lat), PAGE_W'(2 + delay));
    bus.req[id] = 1'b0;
    wait_idle();
  endtask

  task automatic req_loop(input int id, input int n);
    int k;
    for (int t = 0; t < n; t++) begin
      bus.req[id] = 1'b1;
      k = 0;
      while (!bus.strobe[id] && k < 40) begin
        @(negedge clk);
        k++;
      end
      if (!bus.strobe[id]) chk("contention_strobe_wait", PAGE_W'(0), PAGE_W'(1));
      bus.req[id] = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  // Both requesters hold req; grants must alternate starting at `first`.
  task automatic contention(input int n_each, input int first, input int delay);
    logic [ADDR_W-1:0] a [NUM_REQ];
    int id;
    a[0] = 16'h1000;
    a[1] = 16'h1100;
    ack_delay     = delay;
    resp_fixed_en = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.we[i] = 1'b0;
      bus.addr[i*ADDR_W +: ADDR_W] = a[i];
    end
    for (int k = 0; k < 2*n_each; k++) begin
      id = first ^ (k % 2);
      rdata_model = page_of(a[id]);
      push_exp(id, 1'b0, a[id], '0, rdata_model);
    end
    fork
      req_loop(0, n_each);
      req_loop(1, n_each);
    join
    wait_idle();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int up_cnt, n;
    reset     = 1'b1;
    bus.req   = '0;
    bus.we    = '0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    rdata_model   = '0;
    repeat (3) @(negedge clk);
    chk("rst_strobe", PAGE_W'(bus.strobe), PAGE_W'(0));
    chk("rst_rdata", bus.rdata, PAGE_W'(0));
    chk("rst_grant_valid", PAGE_W'(bus.grant_valid), PAGE_W'(0));
    chk("rst_grant_id", PAGE_W'(bus.grant_id), PAGE_W'(0));
    chk("rst_mem_req", PAGE_W'(bus.mem_req), PAGE_W'(0));
    chk("rst_mem_we", PAGE_W'(bus.mem_we), PAGE_W'(0));
    chk("rst_mem_addr", PAGE_W'(bus.mem_addr), PAGE_W'(0));
    chk("rst_mem_wdata", bus.mem_wdata, PAGE_W'(0));
    chk("rst_timeout_err", PAGE_W'(bus.timeout_err), PAGE_W'(0));
    chk("rst_state", PAGE_W'(state_dbg), PAGE_W'(0));
    reset = 1'b0;
    @(negedge clk);

    single_txn(0, 1'b0, 16'h0040, '0, DEADBEEF, 0, 0, 0);

    // mem_ack while idle must not touch rdata
    stray_req = 1;
    repeat (3) @(negedge clk);
    chk("stray_ack_rdata", bus.rdata, rdata_model);
    chk("stray_ack_state", PAGE_W'(state_dbg), PAGE_W'(0));

    single_txn(1, 1'b1, 16'h0123, PAT_A5, ~DEADBEEF, 1, 0, 0);
    single_txn(1, 1'b0, 16'h0124, '0, page_of(16'h0124), 0, 0, 0);
    single_txn(0, 1'b0, 16'h0300, '0, page_of(16'h0300), 1, 1, 0);
    contention(2, 1, 2);
    single_txn(0, 1'b0, 16'h0200, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677,
               page_of(16'h0200), 3, 0, 1);

    // reset in the middle of a memory access; rr_ptr is 1 going in
    no_ack = 1;
    bus.we[1] = 1'b0;
    bus.addr[ADDR_W +: ADDR_W] = 16'h0777;
    bus.req[1] = 1'b1;
    @(negedge clk);
    chk("abort_mem_req_up", PAGE_W'(bus.mem_req), PAGE_W'(1));
    #2 reset = 1'b1;
    #1;
    chk("abort_mem_req", PAGE_W'(bus.mem_req), PAGE_W'(0));
    chk("abort_grant_valid", PAGE_W'(bus.grant_valid), PAGE_W'(0));
    chk("abort_strobe", PAGE_W'(bus.strobe), PAGE_W'(0));
    @(negedge clk);
    bus.req    = '0;
    no_ack     = 0;
    reset      = 1'b0;
    rdata_model = '0;
    @(negedge clk);
    contention(1, 0, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    no_ack = 1;
    bus.we[0] = 1'b0;
    bus.addr[0 +: ADDR_W] = 16'h0BAD;
    bus.req[0] = 1'b1;
    push_exp(0, 1'b0, 16'h0BAD, '0, rdata_model);
    up_cnt = 0;
    n = 0;
    while (!bus.strobe[0] && n < 50) begin
      @(negedge clk);
      n++;
      if (bus.mem_req) up_cnt++;
    end
    chk("timeout_mem_req_cycles", PAGE_W'(up_cnt), PAGE_W'(TIMEOUT_CYCLES));
    chk("timeout_err_set", PAGE_W'(bus.timeout_err), PAGE_W'(1));
    bus.req[0] = 1'b0;
    no_ack = 0;
    wait_idle();
    chk("timeout_err_sticky", PAGE_W'(bus.timeout_err), PAGE_W'(1));
`else
    up_cnt = 0;
    n = 0;
    chk("timeout_err_tied", PAGE_W'(bus.timeout_err), PAGE_W'(up_cnt + n));
`endif

    repeat (4) @(negedge clk);
    chk("exp_q_drained", PAGE_W'(exp_q.size()), PAGE_W'(0));
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench watchdog expired");
  end
endmodule
